sram_burst_ctrl: RTL and testbench

Parametrised single-port SRAM controller between the memory stage and the external 16-bit asynchronous SRAM. It serialises one wide write (WR_BEATS halfwords) or one wide burst read (RD_BEATS halfwords) into consecutive SRAM accesses. It supports per-byte write masking and a configurable number of wait cycles per beat. It holds ready low to freeze the pipeline until the transaction completes.

---
 rtl/sram_burst_if.sv | 28 ++
 rtl/sram_burst_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_if.sv
// Memory-stage side of the SRAM burst controller.
// Request/data bundle plus the ready/rd_valid returns.
interface sram_burst_if #(
  parameter int ADDR_W   = 18,
  parameter int WR_BEATS = 2,
  parameter int RD_BEATS = 4
);
  logic                    wr_en;
  logic                    rd_en;
  logic [ADDR_W-1:0]       addr;
  logic [16*WR_BEATS-1:0]  write_data;
  logic [2*WR_BEATS-1:0]   write_be;
  logic [16*RD_BEATS-1:0]  read_data;
  logic                    rd_valid;
  logic                    ready;

  modport master (
    output wr_en, rd_en, addr,
    output write_data, write_be,
    input  read_data, rd_valid, ready
  );

  modport slave (
    input  wr_en, rd_en, addr,
    input  write_data, write_be,
    output read_data, rd_valid, ready
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Serialises wide writes / burst reads onto a 16-bit
// asynchronous SRAM; ready stalls the pipeline meanwhile.
module sram_burst_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int WR_BEATS = 2,
  parameter int RD_BEATS = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_burst_if.slave       bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);
  localparam int MAXB =
    (WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS;
  localparam int BW =
    (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int WW =
    (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [BW-1:0] WR_LAST = BW'(WR_BEATS - 1);
  localparam logic [BW-1:0] RD_LAST = BW'(RD_BEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [ADDR_W-1:0]       addr_lat_q, addr_lat_d;
  logic [16*WR_BEATS-1:0]  wdata_q, wdata_d;
  logic [2*WR_BEATS-1:0]   be_q, be_d;
  logic                    is_rd_q, is_rd_d;
  logic [16*RD_BEATS-1:0]  shadow_q, shadow_d;
  logic [16*RD_BEATS-1:0]  read_data_q, read_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]       sram_addr_q, sram_addr_d;
  logic [15:0]             dq_out_q, dq_out_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    lb_n_q, lb_n_d;
  logic                    ub_n_q, ub_n_d;
  logic                    beat_end;
  logic [BW-1:0]           last_beat;

  assign bus.ready = !(bus.wr_en | bus.rd_en)
                   || (state_q == DONE);
  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_UB_N = ub_n_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    addr_lat_d  = addr_lat_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    is_rd_d     = is_rd_q;
    shadow_d    = shadow_q;
    read_data_d = read_data_q;
    rd_valid_d  = 1'b0;
    beat_end    = (wait_q == WAIT_LAST);
    last_beat   = (state_q == WRITE) ? WR_LAST : RD_LAST;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          state_d    = bus.wr_en ? WRITE : READ;
          is_rd_d    = !bus.wr_en;
          addr_lat_d = bus.addr;
          wdata_d    = bus.write_data;
          be_d       = bus.write_be;
        end
      end
      WRITE, READ: begin
        if (state_q == READ && beat_end)
          shadow_d[16*int'(beat_q) +: 16] = SRAM_DQ;
        if (beat_end) begin
          wait_d = '0;
          if (beat_q == last_beat) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_rd_q) begin
          read_data_d = shadow_q;
          rd_valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, so every SRAM pin is a flop.
  always_comb begin
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    sram_addr_d = sram_addr_q;
    unique case (1'b1)
      (state_d == WRITE): begin
        ce_n_d      = 1'b0;
        sram_addr_d = addr_lat_d + ADDR_W'(beat_d);
        dq_oe_d     = 1'b1;
        dq_out_d    = wdata_d[16*int'(beat_d) +: 16];
        lb_n_d      = ~be_d[2*int'(beat_d)];
        ub_n_d      = ~be_d[2*int'(beat_d)+1];
        we_n_d      = lb_n_d & ub_n_d;
      end
      (state_d == READ): begin
        ce_n_d      = 1'b0;
        oe_n_d      = 1'b0;
        lb_n_d      = 1'b0;
        ub_n_d      = 1'b0;
        sram_addr_d = addr_lat_d + ADDR_W'(beat_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      addr_lat_q  <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      is_rd_q     <= 1'b0;
      shadow_q    <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      addr_lat_q  <= addr_lat_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      is_rd_q     <= is_rd_d;
      shadow_q    <= shadow_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
    end
  end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: default and WAIT_CYC=2 instances,
// each on a behavioural SRAM, reads checked via scoreboards.
module tb_sram_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_if #(.ADDR_W(18), .WR_BEATS(2), .RD_BEATS(4)) b0 ();
  sram_burst_if #(.ADDR_W(18), .WR_BEATS(2), .RD_BEATS(4)) b1 ();

  wire  [15:0] dq0, dq1;
  logic [17:0] a0, a1;
  logic lb0, ub0, we0, ce0, oe0;
  logic lb1, ub1, we1, ce1, oe1;

  sram_burst_ctrl #(
    .ADDR_W(18), .WR_BEATS(2), .RD_BEATS(4), .WAIT_CYC(0)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0), .SRAM_DQ(dq0),
    .SRAM_ADDR(a0), .SRAM_LB_N(lb0), .SRAM_UB_N(ub0),
    .SRAM_WE_N(we0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0)
  );

  sram_burst_ctrl #(
    .ADDR_W(18), .WR_BEATS(2), .RD_BEATS(4), .WAIT_CYC(2)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1), .SRAM_DQ(dq1),
    .SRAM_ADDR(a1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1),
    .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  assign dq0 = (!ce0 && !oe0 && we0) ? mem0[a0] : 16'bz;
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1] : 16'bz;

  always @(posedge clk) begin
    if (!ce0 && !we0) begin
      if (!lb0) mem0[a0][7:0]  <= dq0[7:0];
      if (!ub0) mem0[a0][15:8] <= dq0[15:8];
    end
    if (!ce1 && !we1) begin
      if (!lb1) mem1[a1][7:0]  <= dq1[7:0];
      if (!ub1) mem1[a1][15:8] <= dq1[15:8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] sb0 [$];
  logic [63:0] sb1 [$];
  int nv0 = 0;
  int nv1 = 0;

  always @(negedge clk) begin
    if (b0.rd_valid === 1'b1) begin
      nv0++;
      if (sb0.size() == 0)
        check("rdv0_unexpected", 64'(b0.rd_valid), 64'd0);
      else
        check("rdata0", b0.read_data, sb0.pop_front());
    end
    if (b1.rd_valid === 1'b1) begin
      nv1++;
      if (sb1.size() == 0)
        check("rdv1_unexpected", 64'(b1.rd_valid), 64'd0);
      else
        check("rdata1", b1.read_data, sb1.pop_front());
    end
  end

  logic [17:0] lg_a   [64];
  logic [15:0] lg_dq  [64];
  logic [4:0]  lg_ctl [64];

  task automatic start(input bit u, input bit wr, input bit rd,
                       input logic [17:0] a,
                       input logic [31:0] d,
                       input logic [3:0] be);
    @(posedge clk);
    #1;
    if (u) begin
      b1.wr_en = wr; b1.rd_en = rd; b1.addr = a;
      b1.write_data = d; b1.write_be = be;
    end else begin
      b0.wr_en = wr; b0.rd_en = rd; b0.addr = a;
      b0.write_data = d; b0.write_be = be;
    end
  endtask

  // Cycle c is logged at the c-th negedge; cycle 0 is the IDLE cycle.
  task automatic wait_ready(input bit u, input bit keep_rd,
                            output int lat);
    lat = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (u) begin
        lg_a[c] = a1; lg_dq[c] = dq1;
        lg_ctl[c] = {ce1, we1, oe1, lb1, ub1};
      end else begin
        lg_a[c] = a0; lg_dq[c] = dq0;
        lg_ctl[c] = {ce0, we0, oe0, lb0, ub0};
      end
      if ((u ? b1.ready : b0.ready) === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (u) begin
      b1.wr_en = 1'b0;
      if (!keep_rd) b1.rd_en = 1'b0;
    end else begin
      b0.wr_en = 1'b0;
      if (!keep_rd) b0.rd_en = 1'b0;
    end
  endtask

  task automatic txn(input bit u, input bit wr, input bit rd,
                     input logic [17:0] a,
                     input logic [31:0] d,
                     input logic [3:0] be,
                     output int lat);
    start(u, wr, rd, a, d, be);
    wait_ready(u, 1'b0, lat);
  endtask

  logic [17:0] wrap_seq [4];
  int lat;

  initial begin
    wrap_seq = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    b0.wr_en = 0; b0.rd_en = 0; b0.addr = '0;
    b0.write_data = '0; b0.write_be = '0;
    b1.wr_en = 0; b1.rd_en = 0; b1.addr = '0;
    b1.write_data = '0; b1.write_be = '0;

    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({ce0, we0, oe0, lb0, ub0}), 64'h1F);
    check("rst_addr", 64'(a0), 64'h0);
    check("rst_rdata", b0.read_data, 64'h0);
    check("rst_rdv", 64'(b0.rd_valid), 64'h0);
    check("rst_ready", 64'(b0.ready), 64'h1);
    check("rst_dq_z", 64'(u0.dq_oe_q), 64'h0);
    rst = 1'b0;

    txn(0, 1, 0, 18'h102, 32'h2222_1111, 4'hF, lat);
    check("seed_wr_lat", 64'(lat), 64'd3);

    txn(0, 1, 0, 18'h100, 32'hBEEF_CAFE, 4'hF, lat);
    check("wr_lat", 64'(lat), 64'd3);
    check("wr_b0_addr", 64'(lg_a[1]), 64'h100);
    check("wr_b0_dq", 64'(lg_dq[1]), 64'hCAFE);
    check("wr_b0_ctl", 64'(lg_ctl[1]), 64'h04);
    check("wr_b1_addr", 64'(lg_a[2]), 64'h101);
    check("wr_b1_dq", 64'(lg_dq[2]), 64'hBEEF);
    check("wr_b1_ctl", 64'(lg_ctl[2]), 64'h04);
    check("wr_done_ctl", 64'(lg_ctl[3][4:2]), 64'h7);
    check("mem_100", 64'(mem0[18'h100]), 64'hCAFE);
    check("mem_101", 64'(mem0[18'h101]), 64'hBEEF);

    sb0.push_back(64'h2222_1111_BEEF_CAFE);
    txn(0, 0, 1, 18'h100, 32'h0, 4'h0, lat);
    check("rd_lat", 64'(lat), 64'd5);
    check("rd_b0_ctl", 64'(lg_ctl[1]), 64'h08);
    check("rd_b3_addr", 64'(lg_a[4]), 64'h103);
    check("rd_done_ctl", 64'(lg_ctl[5][4:2]), 64'h7);
    repeat (3) @(negedge clk);
    check("rdv_count_1", 64'(nv0), 64'd1);
    check("rdata_hold", b0.read_data, 64'h2222_1111_BEEF_CAFE);

    txn(0, 1, 0, 18'h200, 32'h5678_1234, 4'hF, lat);
    txn(0, 1, 0, 18'h200, 32'hAABB_CCDD, 4'b0100, lat);
    check("be_lat", 64'(lat), 64'd3);
    check("be_b0_we", 64'(lg_ctl[1][3]), 64'h1);
    check("be_b1_ctl", 64'(lg_ctl[2]), 64'h05);
    check("mem_200", 64'(mem0[18'h200]), 64'h1234);
    check("mem_201", 64'(mem0[18'h201]), 64'h56BB);

    start(0, 0, 1, 18'h100, 32'h0, 4'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_ready", 64'(b0.ready), 64'h0);
    check("arst_ctl", 64'({ce0, we0, oe0}), 64'h7);
    check("arst_dq_z", 64'(u0.dq_oe_q), 64'h0);
    check("arst_rdata", b0.read_data, 64'h0);
    check("arst_rdv", 64'(b0.rd_valid), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb0.push_back(64'h2222_1111_BEEF_CAFE);
    wait_ready(0, 1'b0, lat);
    check("arst_restart_lat", 64'(lat), 64'd5);
    repeat (3) @(negedge clk);
    check("rdv_count_2", 64'(nv0), 64'd2);

    txn(0, 1, 0, 18'h302, 32'h8888_7777, 4'hF, lat);
    start(0, 1, 1, 18'h300, 32'h0F0E_0D0C, 4'hF);
    wait_ready(0, 1'b1, lat);
    check("both_wr_lat", 64'(lat), 64'd3);
    check("both_wr_ctl", 64'(lg_ctl[1]), 64'h04);
    check("both_done_ctl", 64'(lg_ctl[3][4:2]), 64'h7);
    sb0.push_back(64'h8888_7777_0F0E_0D0C);
    wait_ready(0, 1'b0, lat);
    check("both_rd_lat", 64'(lat), 64'd5);
    check("both_idle_ctl", 64'(lg_ctl[0][4:2]), 64'h7);
    check("both_rd_ctl", 64'(lg_ctl[1]), 64'h08);
    repeat (3) @(negedge clk);
    check("rdv_count_3", 64'(nv0), 64'd3);

    txn(1, 1, 0, 18'h3FFFE, 32'hBBBB_AAAA, 4'hF, lat);
    check("w2_wr_lat", 64'(lat), 64'd7);
    txn(1, 1, 0, 18'h00000, 32'hDDDD_CCCC, 4'hF, lat);
    check("w2_wr_lat2", 64'(lat), 64'd7);
    sb1.push_back(64'hDDDD_CCCC_BBBB_AAAA);
    txn(1, 0, 1, 18'h3FFFE, 32'h0, 4'h0, lat);
    check("w2_rd_lat", 64'(lat), 64'd13);
    for (int c = 1; c <= 12; c++)
      check($sformatf("wrap_addr_c%0d", c),
            64'(lg_a[c]), 64'(wrap_seq[(c-1)/3]));
    repeat (3) @(negedge clk);
    check("rdv1_count", 64'(nv1), 64'd1);
    check("sb0_empty", 64'(sb0.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
